// File: rtl/dmem_arb_pkg.sv
// Shared types, default parameter values and helpers for the data-memory
// arbiter and its burst address generator.
package dmem_arb_pkg;

  localparam int unsigned DEF_AW           = 30;
  localparam int unsigned DEF_DW           = 32;
  localparam int unsigned DEF_MAX_BURST    = 16;
  localparam int unsigned DEF_LEN_W        = 5;
  localparam int unsigned DEF_STARVE_LIMIT = 8;

  // Arbiter phases: CPU owns the port in IDLE, WAIT and DONE; DMA owns it in BURST.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  // Effective burst length: the requested count, capped at the burst maximum.
  function automatic int unsigned clampLen(input int unsigned len,
                                           input int unsigned maxBurst);
    return (len > maxBurst) ? maxBurst : len;
  endfunction

endpackage

// File: rtl/dmem_burst_agu.sv
// Burst address generator: captures the burst base and clamped length when a
// burst is accepted, counts beats, and reports the current beat address and
// whether the current beat is the last one.
module dmem_burst_agu
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [AW-1:0]    base,
  input  logic [LEN_W-1:0] len,
  input  logic             advance,
  output logic [AW-1:0]    beatAddr,
  output logic             lastBeat,
  output logic             lenZero
);

  logic [AW-1:0]    baseLat;
  logic [LEN_W-1:0] lenLat;
  logic [LEN_W-1:0] beatCnt;
  logic [LEN_W-1:0] lenClamped;

  // Clamp the requested length as it arrives so the zero-length decision is
  // available in the same cycle as the start pulse.
  always_comb begin
    lenClamped = LEN_W'(clampLen(32'(len), MAX_BURST));
    lenZero    = (lenClamped == '0);
  end

  // Capture burst parameters on accept; step the beat counter once per beat.
  // NOTE: every clocked register here uses <= so all of them update from the
  // values present before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baseLat <= '0;
      lenLat  <= '0;
      beatCnt <= '0;
    end else if (load) begin
      baseLat <= base;
      lenLat  <= lenClamped;
      beatCnt <= '0;
    end else if (advance) begin
      beatCnt <= beatCnt + LEN_W'(1);
    end
  end

  // Beat address wraps naturally at the word-address width.
  always_comb begin
    beatAddr = baseLat + AW'(beatCnt);
    lastBeat = (beatCnt == lenLat - LEN_W'(1));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the pipeline memory stage (CPU) and a
// block-transfer (DMA) port. The CPU has priority; a pending DMA burst is
// forced in after a bounded number of CPU-busy cycles and then runs to
// completion without preemption, stalling the CPU while it owns the port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned LEN_W        = DEF_LEN_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [3:0]       cpu_wmask,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_start,
  input  logic             dma_we,
  input  logic [AW-1:0]    dma_base,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [DW-1:0]    dma_wdata,
  output logic             dma_wready,
  output logic [DW-1:0]    dma_rdata,
  output logic             dma_rvalid,
  output logic             dma_busy,
  output logic             dma_done,
  output logic             mem_we,
  output logic [3:0]       mem_wmask,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wd,
  input  logic [DW-1:0]    mem_rd
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  arbState_t      state;
  arbState_t      stateNext;
  logic [SW-1:0]  starveCnt;
  logic           dmaWeLat;
  logic           startAccept;
  logic           starveHit;
  logic [AW-1:0]  beatAddr;
  logic           lastBeat;
  logic           lenZero;

  assign startAccept = (state == IDLE) && dma_start;
  assign starveHit   = (starveCnt == SW'(STARVE_LIMIT - 1));

  dmem_burst_agu #(
    .AW       (AW),
    .LEN_W    (LEN_W),
    .MAX_BURST(MAX_BURST)
  ) u_agu (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (startAccept),
    .base    (dma_base),
    .len     (dma_len),
    .advance (state == BURST),
    .beatAddr(beatAddr),
    .lastBeat(lastBeat),
    .lenZero (lenZero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic: accept in IDLE, wait for a CPU gap or starvation, run
  // the burst to its last beat, then a single completion cycle.
  // NOTE: stateNext gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (dma_start) stateNext = lenZero ? DONE : WAIT;
      WAIT:  if (!cpu_req || starveHit) stateNext = BURST;
      BURST: if (lastBeat) stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Starvation counter and latched burst direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
      dmaWeLat  <= 1'b0;
    end else if (startAccept) begin
      starveCnt <= '0;
      dmaWeLat  <= dma_we;
    end else if (state == WAIT && cpu_req) begin
      starveCnt <= starveCnt + SW'(1);
    end
  end

  // Read-burst data is registered: each beat's word appears one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
    end else begin
      dma_rvalid <= (state == BURST) && !dmaWeLat;
      if (state == BURST && !dmaWeLat) dma_rdata <= mem_rd;
    end
  end

  // Port ownership mux and handshake outputs.
  always_comb begin
    mem_we     = cpu_req & cpu_we;
    mem_wmask  = cpu_wmask;
    mem_addr   = cpu_addr;
    mem_wd     = cpu_wdata;
    cpu_stall  = 1'b0;
    dma_wready = 1'b0;
    if (state == BURST) begin
      mem_we     = dmaWeLat;
      mem_wmask  = 4'b1111;
      mem_addr   = beatAddr;
      mem_wd     = dma_wdata;
      cpu_stall  = cpu_req;
      dma_wready = dmaWeLat;
    end
    cpu_rdata = mem_rd;
    dma_busy  = (state == WAIT) || (state == BURST);
    dma_done  = (state == DONE);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Each burst is predicted from its
// timeline: a start cycle, W wait cycles (ended by a CPU gap or the
// starvation limit), min(len,16) beats, and one completion cycle.
module tb_dmem_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int STARVE = 8;
  localparam int MAXB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [3:0]    cpu_wmask;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_start, dma_we;
  logic [AW-1:0] dma_base;
  logic [4:0]    dma_len;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dma_wready, dma_rvalid, dma_busy, dma_done;
  logic          mem_we;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Preloaded memory contents: a fixed, never-zero function of the address.
  function automatic logic [DW-1:0] memPat(input logic [AW-1:0] a);
    return {2'b10, a} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rd = memPat(mem_addr);

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wmask(cpu_wmask),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base),
    .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_busy(dma_busy),
    .dma_done(dma_done),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wmask = 4'h9;
    cpu_addr = 30'h0ABC; cpu_wdata = 32'h1234_5678;
    dma_start = 1'b0; dma_we = 1'b0; dma_base = '0; dma_len = '0; dma_wdata = '0;
    #2;
    checks++;
    if ({cpu_stall, dma_busy, dma_done, dma_wready, dma_rvalid} !== 5'b0 || dma_rdata !== '0) begin
      failures++;
      $display("FAIL reset_ctl got=%b rdata=%h want=00000 rdata=0",
               {cpu_stall, dma_busy, dma_done, dma_wready, dma_rvalid}, dma_rdata);
    end
    checks++;
    if ({mem_we, mem_wmask, mem_addr, mem_wd} !== {1'b1, 4'h9, 30'h0ABC, 32'h1234_5678}) begin
      failures++;
      $display("FAIL reset_mem got=%h want=%h", {mem_we, mem_wmask, mem_addr, mem_wd},
               {1'b1, 4'h9, 30'h0ABC, 32'h1234_5678});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_only;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'h10; cpu_wmask = 4'h3; cpu_wdata = 32'hA5A5;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wmask, mem_wd, cpu_stall} !== {1'b1, 30'h10, 4'h3, 32'hA5A5, 1'b0}) begin
      failures++;
      $display("FAIL cpu_only got=%h want=%h", {mem_we, mem_addr, mem_wmask, mem_wd, cpu_stall},
               {1'b1, 30'h10, 4'h3, 32'hA5A5, 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_wmask = 4'($urandom);
      cpu_addr = 30'($urandom); cpu_wdata = $urandom;
      @(negedge clk);
      checks++;
      if ({mem_we, mem_addr, mem_wmask, cpu_stall, dma_busy, cpu_rdata} !==
          {cpu_req & cpu_we, cpu_addr, cpu_wmask, 1'b0, 1'b0, memPat(cpu_addr)}) begin
        failures++;
        $display("FAIL cpu_only_rand[%0d] we=%b addr=%h mask=%h stall=%b busy=%b", i,
                 mem_we, mem_addr, mem_wmask, cpu_stall, dma_busy);
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // Runs one burst from IDLE back to IDLE, checking every cycle.
  // cpuMode: 0 = CPU idle, 1 = CPU always requesting, 2 = random.
  task automatic run_burst(input string tag, input logic [AW-1:0] base,
                           input logic [4:0] len, input logic we,
                           input int cpuMode, input bit ignorePulse);
    logic          reqV [32];
    logic          weV  [32];
    logic [3:0]    mskV [32];
    logic [AW-1:0] adrV [32];
    logic [DW-1:0] cwdV [32];
    logic [DW-1:0] dwdV [32];
    int L, W, total, ignoreAt, beat;
    logic isBurst, isWait, isDone, rvE;
    logic [AW-1:0] expAddr;
    logic [66:0] expMem, gotMem;
    logic [4:0] expCtl, gotCtl;
    L = (int'(len) > MAXB) ? MAXB : int'(len);
    for (int i = 0; i < 32; i++) begin
      reqV[i] = (cpuMode == 0) ? 1'b0 : (cpuMode == 1) ? 1'b1 : 1'($urandom);
      weV[i]  = 1'($urandom);
      mskV[i] = 4'($urandom);
      adrV[i] = 30'($urandom);
      cwdV[i] = $urandom;
      dwdV[i] = $urandom;
    end
    W = 0;
    if (L != 0) begin
      W = 1;
      while (reqV[W] && W != STARVE) W++;
    end
    total = (L == 0) ? 3 : W + L + 2;
    ignoreAt = ignorePulse ? 1 + $urandom_range(0, total - 3) : -1;
    for (int c = 0; c < total; c++) begin
      cpu_req = reqV[c]; cpu_we = weV[c]; cpu_wmask = mskV[c];
      cpu_addr = adrV[c]; cpu_wdata = cwdV[c]; dma_wdata = dwdV[c];
      if (c == 0) begin
        dma_start = 1'b1; dma_we = we; dma_base = base; dma_len = len;
      end else begin
        dma_start = (c == ignoreAt);
        dma_we = 1'($urandom); dma_base = 30'($urandom); dma_len = 5'($urandom_range(1, 31));
      end
      @(negedge clk);
      isBurst = (L != 0) && c >= W + 1 && c <= W + L;
      isWait  = (L != 0) && c >= 1 && c <= W;
      isDone  = (L == 0) ? (c == 1) : (c == W + L + 1);
      rvE     = !we && (L != 0) && c >= W + 2 && c <= W + L + 1;
      beat    = c - W - 1;
      expAddr = isBurst ? base + 30'(beat) : adrV[c];
      expMem  = isBurst ? {we, 4'hF, expAddr, dwdV[c]}
                        : {reqV[c] & weV[c], mskV[c], adrV[c], cwdV[c]};
      expCtl  = {isBurst & reqV[c], isWait | isBurst, isDone, isBurst & we, rvE};
      gotMem  = {mem_we, mem_wmask, mem_addr, mem_wd};
      gotCtl  = {cpu_stall, dma_busy, dma_done, dma_wready, dma_rvalid};
      checks++;
      if (gotMem !== expMem) begin
        failures++;
        $display("FAIL %s mem cyc=%0d got=%h want=%h", tag, c, gotMem, expMem);
      end
      checks++;
      if (gotCtl !== expCtl) begin
        failures++;
        $display("FAIL %s ctl(stall,busy,done,wready,rvalid) cyc=%0d got=%b want=%b",
                 tag, c, gotCtl, expCtl);
      end
      checks++;
      if (cpu_rdata !== memPat(expAddr)) begin
        failures++;
        $display("FAIL %s cpu_rdata cyc=%0d got=%h want=%h", tag, c, cpu_rdata, memPat(expAddr));
      end
      if (rvE) begin
        checks++;
        if (dma_rdata !== memPat(base + 30'(c - W - 2))) begin
          failures++;
          $display("FAIL %s dma_rdata cyc=%0d got=%h want=%h", tag, c, dma_rdata,
                   memPat(base + 30'(c - W - 2)));
        end
      end
      @(posedge clk); #1;
    end
    dma_start = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic test_dma_write_idle;
    run_burst("wr_idle", 30'h100, 5'd4, 1'b1, 0, 1'b0);
  endtask

  task automatic test_starvation;
    run_burst("starve_rd", 30'($urandom), 5'd2, 1'b0, 1, 1'b0);
    run_burst("starve_wr", 30'($urandom), 5'd3, 1'b1, 1, 1'b0);
  endtask

  task automatic test_clamp_zero;
    run_burst("clamp31", 30'h2000, 5'd31, 1'b1, 2, 1'b0);
    run_burst("clamp17_rd", 30'h3000, 5'd17, 1'b0, 0, 1'b0);
    run_burst("len0", 30'h4000, 5'd0, 1'b1, 2, 1'b0);
  endtask

  task automatic test_wrap_ignore;
    run_burst("wrap_rd", 30'h3FFF_FFFF, 5'd2, 1'b0, 0, 1'b1);
    run_burst("wrap_wr", 30'h3FFF_FFFE, 5'd5, 1'b1, 2, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++)
      run_burst("rand", 30'($urandom), 5'($urandom_range(0, 31)), 1'($urandom), 2, 1'($urandom));
  endtask

  task automatic test_reset_mid_burst;
    logic [AW-1:0] base;
    base = 30'($urandom);
    cpu_req = 1'b0; cpu_we = 1'b0;
    dma_start = 1'b1; dma_we = 1'b0; dma_base = base; dma_len = 5'd8;
    @(posedge clk); #1;                 // WAIT
    dma_start = 1'b0;
    @(posedge clk); #1;                 // beat 0
    @(posedge clk); #1;                 // beat 1
    @(negedge clk);
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== memPat(base)) begin
      failures++;
      $display("FAIL rst_mid pre rvalid=%b rdata=%h want 1 %h", dma_rvalid, dma_rdata, memPat(base));
    end
    @(posedge clk); #1;                 // beat 2
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wmask = 4'h5; cpu_addr = 30'h77; cpu_wdata = 32'hCAFE;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_stall, dma_busy, dma_done, dma_wready, dma_rvalid} !== 5'b0 || dma_rdata !== '0) begin
      failures++;
      $display("FAIL rst_mid ctl got=%b rdata=%h want=00000 rdata=0",
               {cpu_stall, dma_busy, dma_done, dma_wready, dma_rvalid}, dma_rdata);
    end
    checks++;
    if ({mem_we, mem_wmask, mem_addr, mem_wd} !== {1'b1, 4'h5, 30'h77, 32'hCAFE}) begin
      failures++;
      $display("FAIL rst_mid mem got=%h want=%h", {mem_we, mem_wmask, mem_addr, mem_wd},
               {1'b1, 4'h5, 30'h77, 32'hCAFE});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (dma_done !== 1'b0 || dma_busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid hold[%0d] done=%b busy=%b want 0 0", i, dma_done, dma_busy);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    run_burst("after_rst", 30'($urandom), 5'd8, 1'b0, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_dma_write_idle();
    test_starvation();
    test_clamp_zero();
    test_wrap_ignore();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
